// File: rtl/icache_fill_responder_if.sv
// icache_fill_responder_if: per-core icache request/response lines
// plus the shared RAM read port, grouped for the fill responder.
interface icache_fill_responder_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;
  logic                  ramREN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramload;
  logic [1:0]            ramstate;

  modport master (
    output iREN, iaddr, ramload, ramstate,
    input  iwait, iload, ramREN, ramaddr
  );

  modport slave (
    input  iREN, iaddr, ramload, ramstate,
    output iwait, iload, ramREN, ramaddr
  );
endinterface

// File: rtl/icache_fill_responder.sv
// icache_fill_responder: round-robin icache fill arbiter onto one RAM port.
// Optional per-core fill counters under ICACHE_FILL_STATS_EN.
module icache_fill_responder #(
  parameter int CPUS    = 2,
  parameter int CPUID_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic CLK,
  input  logic nRST,
`ifdef ICACHE_FILL_STATS_EN
  output logic [CPUS-1:0][15:0] fill_count,
`endif
  icache_fill_responder_if.slave bus
);

  typedef enum logic {IDLE, READ} state_t;
  typedef enum logic [1:0] {
    FREE, BUSY, ACCESS, ERROR
  } ramstate_t;

  state_t              state_q, state_d;
  logic [CPUID_W-1:0]  grant_q, grant_d;
  logic [CPUID_W-1:0]  last_q, last_d;
  logic [29:0]         addr_q, addr_d;

  logic [CPUID_W-1:0]  pick;
  logic                req_any;
  logic                abort;
  logic                hit;
  logic [29:0]         cur_word;
  logic [CPUS-1:0]     iwait_c;
  logic [CPUS-1:0][31:0] iload_c;
  int                  idx;

  // Walk downward so the nearest requester after last wins.
  always_comb begin
    req_any = |bus.iREN;
    pick    = '0;
    idx     = 0;
    for (int k = CPUS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % CPUS;
      if (bus.iREN[idx]) pick = CPUID_W'(idx);
    end
  end

  always_comb begin
    cur_word = bus.iaddr[grant_q][31:2];
    abort    = !bus.iREN[grant_q] ||
               (cur_word != addr_q);
    hit      = (state_q == READ) && !abort &&
               (bus.ramstate == ACCESS);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CPUID_W'(CPUS - 1);
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = READ;
          grant_d = pick;
          addr_d  = bus.iaddr[pick][31:2];
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait_c = '1;
    iload_c = '0;
    if (hit) begin
      iwait_c[grant_q] = 1'b0;
      iload_c[grant_q] = bus.ramload;
    end
  end

  assign bus.iwait   = iwait_c;
  assign bus.iload   = iload_c;
  assign bus.ramREN  = (state_q == READ);
  assign bus.ramaddr = (state_q == READ) ?
                       {addr_q, 2'b00} : 32'h0;

`ifdef ICACHE_FILL_STATS_EN
  logic [CPUS-1:0][15:0] fill_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fill_q <= '0;
    end else begin
      for (int c = 0; c < CPUS; c++) begin
        if (!iwait_c[c] && fill_q[c] != 16'hFFFF)
          fill_q[c] <= fill_q[c] + 16'd1;
      end
    end
  end

  assign fill_count = fill_q;
`endif

endmodule

// File: tb/tb_icache_fill_responder.sv
// tb_icache_fill_responder: directed scenarios plus a randomized
// run scored against a transaction-level model of the responder.
module tb_icache_fill_responder;

  localparam int CPUS = 2;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic CLK;
  logic nRST;
  int   errs;
  int   nchk;

  icache_fill_responder_if #(.CPUS(CPUS)) bus ();

`ifdef ICACHE_FILL_STATS_EN
  logic [CPUS-1:0][15:0] fill_count;
`endif

  icache_fill_responder #(.CPUS(CPUS)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
`ifdef ICACHE_FILL_STATS_EN
    .fill_count (fill_count),
`endif
    .bus        (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    nRST         = 1'b0;
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.ramload  = '0;
    bus.ramstate = RS_FREE;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset;
    nRST         = 1'b0;
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.ramload  = '0;
    bus.ramstate = RS_FREE;
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0) begin
      errs++;
      $display("FAIL reset_ram got REN=%b addr=%h want 0/0",
               bus.ramREN, bus.ramaddr);
    end
    nchk++;
    if (bus.iwait !== 2'b11 || bus.iload !== '0) begin
      errs++;
      $display("FAIL reset_core got iwait=%b iload=%h want 11/0",
               bus.iwait, bus.iload);
    end
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_single;
    bus.iREN     = 2'b01;
    bus.iaddr[0] = 32'h04;
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) begin
      errs++;
      $display("FAIL single_c0 got REN=%b iwait=%b want 0/11",
               bus.ramREN, bus.iwait);
    end
    tick();
    bus.ramstate = RS_ACCESS;
    bus.ramload  = 32'h3C010004;
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h04) begin
      errs++;
      $display("FAIL single_ram got REN=%b addr=%h want 1/04",
               bus.ramREN, bus.ramaddr);
    end
    nchk++;
    if (bus.iwait !== 2'b10 || bus.iload[0] !== 32'h3C010004 ||
        bus.iload[1] !== 32'h0) begin
      errs++;
      $display("FAIL single_hit got iwait=%b iload0=%h want 10/3c010004",
               bus.iwait, bus.iload[0]);
    end
    tick();
    bus.iREN     = 2'b00;
    bus.ramstate = RS_FREE;
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) begin
      errs++;
      $display("FAIL single_done got REN=%b iwait=%b want 0/11",
               bus.ramREN, bus.iwait);
    end
    tick();
  endtask

  task automatic test_contention;
    int order [3];
    logic [31:0] a;
    order = '{0, 1, 0};
    do_reset();
    bus.iREN     = 2'b11;
    bus.iaddr[0] = 32'h000;
    bus.iaddr[1] = 32'h100;
    for (int s = 0; s < 3; s++) begin
      a = (order[s] == 0) ? 32'h000 : 32'h100;
      bus.ramstate = RS_BUSY;
      @(negedge CLK);
      nchk++;
      if (bus.ramREN !== 1'b0) begin
        errs++;
        $display("FAIL cont_idle%0d got REN=%b want 0", s, bus.ramREN);
      end
      tick();
      for (int b = 0; b < 2; b++) begin
        @(negedge CLK);
        nchk++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== a ||
            bus.iwait !== 2'b11) begin
          errs++;
          $display("FAIL cont_busy%0d got REN=%b addr=%h iwait=%b want 1/%h/11",
                   s, bus.ramREN, bus.ramaddr, bus.iwait, a);
        end
        tick();
      end
      bus.ramstate = RS_ACCESS;
      bus.ramload  = 32'hA0000000 + s;
      @(negedge CLK);
      nchk++;
      if (bus.iwait[order[s]] !== 1'b0 ||
          bus.iwait[1-order[s]] !== 1'b1 ||
          bus.iload[order[s]] !== 32'hA0000000 + s) begin
        errs++;
        $display("FAIL cont_hit%0d got iwait=%b iload=%h want core %0d",
                 s, bus.iwait, bus.iload, order[s]);
      end
      tick();
    end
    bus.iREN     = 2'b00;
    bus.ramstate = RS_FREE;
    tick();
  endtask

  task automatic test_abort;
    do_reset();
    bus.iREN     = 2'b11;
    bus.iaddr[0] = 32'h08;
    bus.iaddr[1] = 32'h200;
    bus.ramstate = RS_BUSY;
    tick();
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h08) begin
      errs++;
      $display("FAIL abort_rd got REN=%b addr=%h want 1/08",
               bus.ramREN, bus.ramaddr);
    end
    tick();
    bus.iREN = 2'b10;
    @(negedge CLK);
    nchk++;
    if (bus.iwait !== 2'b11) begin
      errs++;
      $display("FAIL abort_wait got iwait=%b want 11", bus.iwait);
    end
    tick();
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) begin
      errs++;
      $display("FAIL abort_drop got REN=%b iwait=%b want 0/11",
               bus.ramREN, bus.iwait);
    end
    tick();
    bus.ramstate = RS_ACCESS;
    bus.ramload  = 32'h11112222;
    @(negedge CLK);
    nchk++;
    if (bus.ramaddr !== 32'h200 || bus.iwait !== 2'b01 ||
        bus.iload[1] !== 32'h11112222) begin
      errs++;
      $display("FAIL abort_next got addr=%h iwait=%b want 200/01",
               bus.ramaddr, bus.iwait);
    end
    tick();
    bus.iREN     = 2'b00;
    bus.ramstate = RS_FREE;
    tick();
  endtask

  task automatic test_addr_change;
    do_reset();
    bus.iREN     = 2'b01;
    bus.iaddr[0] = 32'h10;
    bus.ramstate = RS_BUSY;
    tick();
    tick();
    bus.iaddr[0] = 32'h14;
    bus.ramstate = RS_ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    @(negedge CLK);
    nchk++;
    if (bus.iwait !== 2'b11 || bus.iload !== '0) begin
      errs++;
      $display("FAIL chg_stale got iwait=%b iload=%h want 11/0",
               bus.iwait, bus.iload);
    end
    tick();
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b0) begin
      errs++;
      $display("FAIL chg_idle got REN=%b want 0", bus.ramREN);
    end
    tick();
    bus.ramload = 32'hCAFEF00D;
    @(negedge CLK);
    nchk++;
    if (bus.ramaddr !== 32'h14 || bus.iwait !== 2'b10 ||
        bus.iload[0] !== 32'hCAFEF00D) begin
      errs++;
      $display("FAIL chg_hit got addr=%h iwait=%b iload0=%h want 14/10/cafef00d",
               bus.ramaddr, bus.iwait, bus.iload[0]);
    end
    tick();
    bus.iREN     = 2'b00;
    bus.ramstate = RS_FREE;
    tick();
  endtask

  task automatic test_error;
    do_reset();
    bus.iREN     = 2'b01;
    bus.iaddr[0] = 32'h20;
    tick();
    bus.ramstate = RS_ERROR;
    for (int e = 0; e < 3; e++) begin
      @(negedge CLK);
      nchk++;
      if (bus.ramREN !== 1'b1 || bus.iwait !== 2'b11) begin
        errs++;
        $display("FAIL err_hold%0d got REN=%b iwait=%b want 1/11",
                 e, bus.ramREN, bus.iwait);
      end
      tick();
    end
    bus.ramstate = RS_ACCESS;
    bus.ramload  = 32'h0BADF00D;
    @(negedge CLK);
    nchk++;
    if (bus.iwait !== 2'b10 || bus.iload[0] !== 32'h0BADF00D) begin
      errs++;
      $display("FAIL err_hit got iwait=%b iload0=%h want 10/0badf00d",
               bus.iwait, bus.iload[0]);
    end
    tick();
    bus.iREN     = 2'b00;
    bus.ramstate = RS_FREE;
    tick();
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    bus.iREN     = 2'b10;
    bus.iaddr[1] = 32'h40;
    bus.ramstate = RS_BUSY;
    tick();
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b1) begin
      errs++;
      $display("FAIL rst_pre got REN=%b want 1", bus.ramREN);
    end
    #2;
    nRST = 1'b0;
    #1;
    nchk++;
    if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0 ||
        bus.iwait !== 2'b11 || bus.iload !== '0) begin
      errs++;
      $display("FAIL rst_async got REN=%b addr=%h iwait=%b want 0/0/11",
               bus.ramREN, bus.ramaddr, bus.iwait);
    end
    tick();
    nRST = 1'b1;
    tick();
    @(negedge CLK);
    nchk++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin
      errs++;
      $display("FAIL rst_resume got REN=%b addr=%h want 1/40",
               bus.ramREN, bus.ramaddr);
    end
    tick();
    bus.iREN     = 2'b00;
    bus.ramstate = RS_FREE;
    tick();
  endtask

  task automatic test_random;
    bit          m_act;
    int          m_core;
    logic [31:0] m_addr;
    int          m_last;
    bit          rq [CPUS];
    logic [31:0] ad [CPUS];
    bit          got [CPUS];
    bit          stale;
    bit          deliver;
    int          r;
    int          cand [$];
    logic [CPUS-1:0]       e_wait;
    logic [CPUS-1:0][31:0] e_load;
    do_reset();
    m_act  = 1'b0;
    m_core = 0;
    m_addr = '0;
    m_last = CPUS - 1;
    for (int c = 0; c < CPUS; c++) begin
      rq[c]  = 1'b0;
      ad[c]  = '0;
      got[c] = 1'b0;
    end
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        r = $urandom_range(0, 99);
        if (rq[c] && got[c]) rq[c] = 1'b0;
        else if (rq[c] && r < 4) rq[c] = 1'b0;
        else if (rq[c] && r < 8)
          ad[c][31:2] = 30'($urandom_range(0, 31));
        else if (!rq[c] && r < 40) begin
          rq[c] = 1'b1;
          ad[c][31:2] = 30'($urandom_range(0, 31));
        end
        ad[c][1:0]   = 2'($urandom_range(0, 3));
        bus.iREN[c]  = rq[c];
        bus.iaddr[c] = ad[c];
      end
      bus.ramstate = 2'($urandom_range(0, 3));
      bus.ramload  = $urandom;
      @(negedge CLK);
      e_wait  = '1;
      e_load  = '0;
      deliver = 1'b0;
      stale   = 1'b0;
      if (m_act) begin
        stale = !rq[m_core] ||
                (ad[m_core][31:2] != m_addr[31:2]);
        deliver = !stale && (bus.ramstate == RS_ACCESS);
        if (deliver) begin
          e_wait[m_core] = 1'b0;
          e_load[m_core] = bus.ramload;
        end
      end
      nchk++;
      if (bus.ramREN !== m_act) begin
        errs++;
        $display("FAIL rnd_ren cyc %0d got %b want %b",
                 n, bus.ramREN, m_act);
      end
      nchk++;
      if (bus.ramaddr !== (m_act ? m_addr : 32'h0)) begin
        errs++;
        $display("FAIL rnd_addr cyc %0d got %h want %h",
                 n, bus.ramaddr, m_act ? m_addr : 32'h0);
      end
      nchk++;
      if (bus.iwait !== e_wait) begin
        errs++;
        $display("FAIL rnd_iwait cyc %0d got %b want %b",
                 n, bus.iwait, e_wait);
      end
      nchk++;
      if (bus.iload !== e_load) begin
        errs++;
        $display("FAIL rnd_iload cyc %0d got %h want %h",
                 n, bus.iload, e_load);
      end
      for (int c = 0; c < CPUS; c++)
        got[c] = deliver && (c == m_core);
      if (m_act) begin
        if (stale) m_act = 1'b0;
        else if (deliver) begin
          m_act  = 1'b0;
          m_last = m_core;
        end
      end else begin
        cand.delete();
        for (int k = 1; k <= CPUS; k++)
          if (rq[(m_last + k) % CPUS])
            cand.push_back((m_last + k) % CPUS);
        if (cand.size() > 0) begin
          m_act  = 1'b1;
          m_core = cand[0];
          m_addr = {ad[m_core][31:2], 2'b00};
        end
      end
      tick();
    end
    bus.iREN     = '0;
    bus.ramstate = RS_FREE;
    tick();
  endtask

`ifdef ICACHE_FILL_STATS_EN
  task automatic test_stats;
    do_reset();
    bus.iREN     = 2'b10;
    bus.iaddr[1] = 32'h80;
    bus.ramstate = RS_ACCESS;
    for (int s = 0; s < 5; s++) begin
      tick();
      tick();
    end
    bus.iREN = 2'b00;
    @(negedge CLK);
    nchk++;
    if (fill_count[1] !== 16'd5 || fill_count[0] !== 16'd0) begin
      errs++;
      $display("FAIL stats_cnt got c1=%0d c0=%0d want 5/0",
               fill_count[1], fill_count[0]);
    end
    dut.fill_q[1] = 16'hFFFE;
    tick();
    bus.iREN = 2'b10;
    for (int s = 0; s < 2; s++) begin
      tick();
      tick();
    end
    bus.iREN = 2'b00;
    @(negedge CLK);
    nchk++;
    if (fill_count[1] !== 16'hFFFF) begin
      errs++;
      $display("FAIL stats_sat got %h want ffff", fill_count[1]);
    end
    bus.ramstate = RS_FREE;
    tick();
  endtask
`endif

  initial begin
    errs = 0;
    nchk = 0;
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_addr_change();
    test_error();
    test_reset_mid_read();
    test_random();
`ifdef ICACHE_FILL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
